instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
Fetch stage upstream of decode/control and the immediate extender. Owns the PC, issues word reads to instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to decode on a valid/ready handshake. A taken branch/jump redirects the PC, flushes the queue and discards in-flight responses, so decode never sees stale instructions.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUT, 2, max outstanding imem requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  read request this cycle
imem_addr  out  32  word address of request (bits[1:0]=00)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses in request order
imem_rdata  in  32  instruction word
redirect_valid  in  1  branch/jump taken, flush
redirect_pc  in  32  new fetch PC
instr_valid  out  1  queue head valid
instr  out  32  head instruction (bits[31:7] feed extender)
instr_pc  out  32  PC of head instruction
instr_ready  in  1  decode consumes head
fetch_fault  out  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high on clk: reset held high at a rising edge clears all state. After reset: pc=RESET_PC, count=0, outstanding=0, drop=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
- Request rule: imem_req=1 iff !reset && !redirect_valid && (count+outstanding) < DEPTH && outstanding < MAX_OUT. imem_addr=pc. On imem_req&&imem_gnt: pc<=pc+4 (32-bit wrap at 0xFFFF_FFFC->0), outstanding+=1. Credit check guarantees a FIFO slot for each response; no response is ever dropped for lack of space.
- Request PC tracking: small in-order tag FIFO (depth MAX_OUT) holds the PC of each granted request; popped on each imem_rvalid.
- Response: on imem_rvalid, outstanding-=1 (same cycle as a grant: net unchanged). If drop==0, push {imem_rdata, tag PC} into the queue; if drop>0, discard and drop-=1.
- Output: instr_valid=(count!=0); instr/instr_pc = head entry, registered FIFO storage, no combinational path from imem_rdata to instr. Zero-latency bypass not permitted: a response is visible on instr the cycle after imem_rvalid.
- Pop on instr_valid&&instr_ready. Simultaneous push and pop with count=DEPTH is impossible by credit rule; with count=0 push only.
- Redirect (priority over everything but reset): at the edge, count<=0, pc<=redirect_pc (bits[1:0] forced 00), drop<=outstanding minus any rvalid that same cycle (responses arriving that cycle are discarded). Grant and pop in the redirect cycle are ignored (imem_req is 0). instr_valid=0 the cycle after redirect. First post-redirect request issues the next cycle.
- Back-to-back redirects: latest wins; drop accumulates correctly.
- Counters: count width clog2(DEPTH)+1, outstanding/drop clog2(MAX_OUT)+1; pointers wrap modulo DEPTH.
- Reset mid-transaction: late imem_rvalid after reset deasserts is not expected; memory is reset with the same reset.

Optional Feature:
FETCH_MISALIGN_FAULT_EN: when defined, a redirect with redirect_pc[1:0]!=00 sets fetch_fault=1 (sticky until reset), stops further requests (imem_req=0), still flushes. When undefined, fetch_fault tied 0 and bits[1:0] are silently cleared.

Test Plan:
- Reset then imem always granting, 1-cycle rvalid, instr_ready=1 -> imem_addr 0,4,8,...; instr_pc 0,4,8 in order, instr matches rdata, first instr_valid 2 cycles after first grant.
- instr_ready=0 throughout -> exactly 4 entries queued, imem_req drops to 0 with count=4, outstanding=0; raising ready drains 0,4,8,C then resumes at 0x10.
- Redirect to 0x100 with 2 outstanding -> next 2 responses discarded, instr_valid low, next instr_pc=0x100.
- Redirect in same cycle as imem_rvalid and instr_ready -> that response discarded, no pop counted, queue empty next cycle.
- pc=0xFFFF_FFFC grant -> next imem_addr=0x0000_0000.
- Macro defined, redirect_pc=0x102 -> fetch_fault=1, imem_req stays 0 until reset; macro undefined -> fetch at 0x100, fetch_fault=0.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response, redirect and decode handshake.
// The master modport is the fetch unit's view; slave is the memory/decode environment.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: PC, credit-limited imem requests, PC tag FIFO and instruction queue.
// Optional macro FETCH_MISALIGN_FAULT_EN: misaligned redirect raises a sticky fetch_fault and halts fetch.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_queue_if.master fq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT) + 1;
    localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [CW:0]   DEPTH_L  = (CW + 1)'(DEPTH);
    localparam logic [OW-1:0] MAX_L    = OW'(MAX_OUT);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUT - 1);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    fetch_state_e state, state_next;

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic [31:0]   tag_pc  [MAX_OUT];
    logic [TW-1:0] tag_wr, tag_rd;

    logic          fetch_en;
    logic [CW:0]   credit_used;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: HALTED is only reachable when the fault feature is built in
    always_comb begin
        state_next = state;
`ifdef FETCH_MISALIGN_FAULT_EN
        if (fq.redirect_valid && (fq.redirect_pc[1:0] != 2'b00)) begin
            state_next = HALTED;
        end
`endif
    end

    // State outputs
    always_comb begin
        fetch_en = (state == FETCH);
    end

`ifdef FETCH_MISALIGN_FAULT_EN
    assign fq.fetch_fault = (state == HALTED);
`else
    assign fq.fetch_fault = 1'b0;
`endif

    // Credit check reserves a queue slot for every request in flight
    assign credit_used = {1'b0, count} + (CW + 1)'(outstanding);

    assign fq.imem_req  = !reset && !fq.redirect_valid && fetch_en
                          && (credit_used < DEPTH_L) && (outstanding < MAX_L);
    assign fq.imem_addr = pc;

    assign grant = fq.imem_req && fq.imem_gnt;
    assign rsp   = fq.imem_rvalid;
    assign push  = rsp && (drop == '0) && !fq.redirect_valid;
    assign pop   = fq.instr_valid && fq.instr_ready && !fq.redirect_valid;

    assign fq.instr_valid = (count != '0);
    assign fq.instr       = q_instr[rd_ptr];
    assign fq.instr_pc    = q_pc[rd_ptr];

    // PC tags follow responses in order; stale responses still consume their tag
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_wr <= '0;
            tag_rd <= '0;
            tag_pc <= '{default: '0};
        end else begin
            if (grant) begin
                tag_pc[tag_wr] <= pc;
                tag_wr         <= tag_inc(tag_wr);
            end
            if (rsp) begin
                tag_rd <= tag_inc(tag_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_instr     <= '{default: '0};
            q_pc        <= '{default: '0};
        end else if (fq.redirect_valid) begin
            // Every request still in flight is stale, including one answered this cycle
            pc          <= {fq.redirect_pc[31:2], 2'b00};
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - OW'(rsp);
            drop        <= outstanding - OW'(rsp);
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + OW'(grant) - OW'(rsp);
            if (rsp && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
            if (push) begin
                q_instr[wr_ptr] <= fq.imem_rdata;
                q_pc[wr_ptr]    <= tag_pc[tag_rd];
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed phases push expected {pc, instr}; a monitor pops on each consumed head.
module tb_instr_fetch_queue;

    logic clk = 1'b0;
    logic reset;
    logic resp_en;

    always #5 clk = ~clk;

    instr_fetch_queue_if ifc ();

    instr_fetch_queue #(
        .DEPTH    (4),
        .MAX_OUT  (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (ifc.master)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] sb_q [$];
    logic [31:0] pend_q [$];
    logic [31:0] resp_addr;
    logic [63:0] exp_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        sb_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.imem_gnt       = 1'b0;
        ifc.instr_ready    = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        resp_en            = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Grant exactly n requests, checking each granted address
    task automatic grant_n(input int n, input logic [31:0] start);
        int i;
        int budget;
        i = 0;
        budget = 40;
        ifc.imem_gnt = 1'b1;
        while (i < n && budget > 0) begin
            @(negedge clk);
            if (ifc.imem_req) begin
                check("grant_addr", ifc.imem_addr, start + 32'(4 * i));
                i++;
            end
            budget--;
            tick();
        end
        ifc.imem_gnt = 1'b0;
        tests++;
        if (i < n) begin
            fails++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", i, n);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 60;
        while (sb_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    // Memory model: records grants at negedge, answers one per cycle in order
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
            end else if (ifc.imem_req && ifc.imem_gnt) begin
                pend_q.push_back(ifc.imem_addr);
            end
        end
    end

    initial begin
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && resp_en && pend_q.size() > 0) begin
                resp_addr       = pend_q.pop_front();
                ifc.imem_rvalid = 1'b1;
                ifc.imem_rdata  = mem_word(resp_addr);
            end else begin
                ifc.imem_rvalid = 1'b0;
                ifc.imem_rdata  = '0;
            end
        end
    end

    // Monitor: a consumed head must match the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ifc.instr_valid && ifc.instr_ready && !ifc.redirect_valid) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got pc %h instr %h expected no instruction",
                             ifc.instr_pc, ifc.instr);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("sb_pc", ifc.instr_pc, exp_e[63:32]);
                    check("sb_instr", ifc.instr, exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset              = 1'b1;
        resp_en            = 1'b1;
        ifc.imem_gnt       = 1'b0;
        ifc.instr_ready    = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_req", ifc.imem_req, 32'd0);
        check("rst_valid", ifc.instr_valid, 32'd0);
        check("rst_instr", ifc.instr, 32'd0);
        check("rst_instr_pc", ifc.instr_pc, 32'd0);
        check("rst_fault", ifc.fetch_fault, 32'd0);
        tick();
        reset = 1'b0;

        // Streaming: addresses 0,4,8..., first valid two cycles after first grant
        ifc.instr_ready = 1'b1;
        ifc.imem_gnt    = 1'b1;
        for (int k = 0; k < 6; k++) expect_instr(32'(4 * k));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t1_req", ifc.imem_req, 32'd1);
            check("t1_addr", ifc.imem_addr, 32'(4 * i));
            if (i < 3) check("t1_valid_lat", ifc.instr_valid, 32'(i == 2));
            tick();
        end
        ifc.imem_gnt = 1'b0;
        wait_drain();

        // Decode stalled: queue fills to 4, requests stop, then drain and resume at 0x10
        do_reset();
        ifc.imem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) expect_instr(32'(4 * k));
        repeat (8) tick();
        @(negedge clk);
        check("t2_req_full", ifc.imem_req, 32'd0);
        check("t2_valid", ifc.instr_valid, 32'd1);
        check("t2_head_pc", ifc.instr_pc, 32'd0);
        tick();
        ifc.imem_gnt    = 1'b0;
        ifc.instr_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("t2_resume_req", ifc.imem_req, 32'd1);
        check("t2_resume_addr", ifc.imem_addr, 32'h10);
        tick();
        expect_instr(32'h10);
        grant_n(1, 32'h10);
        wait_drain();

        // Redirect with two responses outstanding: both discarded
        do_reset();
        ifc.instr_ready = 1'b1;
        resp_en = 1'b0;
        grant_n(2, 32'h0);
        @(negedge clk);
        check("t3_req_maxout", ifc.imem_req, 32'd0);
        tick();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h100;
        @(negedge clk);
        check("t3_req_redir", ifc.imem_req, 32'd0);
        tick();
        ifc.redirect_valid = 1'b0;
        resp_en = 1'b1;
        expect_instr(32'h100);
        @(negedge clk);
        check("t3_valid_flushed", ifc.instr_valid, 32'd0);
        tick();
        grant_n(1, 32'h100);
        @(negedge clk);
        check("t3_valid_discard", ifc.instr_valid, 32'd0);
        wait_drain();

        // Redirect coinciding with a response and a ready head
        do_reset();
        grant_n(2, 32'h0);
        ifc.instr_ready    = 1'b1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h200;
        @(negedge clk);
        check("t4_valid_before", ifc.instr_valid, 32'd1);
        tick();
        ifc.redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_after", ifc.instr_valid, 32'd0);
        check("t4_req", ifc.imem_req, 32'd1);
        check("t4_addr", ifc.imem_addr, 32'h200);
        tick();
        expect_instr(32'h200);
        grant_n(1, 32'h200);
        wait_drain();

        // Back-to-back redirects: the later target wins, drop accumulates
        do_reset();
        ifc.instr_ready = 1'b1;
        resp_en = 1'b0;
        grant_n(2, 32'h0);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h300;
        tick();
        ifc.redirect_pc = 32'h400;
        resp_en = 1'b1;
        tick();
        ifc.redirect_valid = 1'b0;
        expect_instr(32'h400);
        grant_n(1, 32'h400);
        wait_drain();

        // PC wraps from 0xFFFF_FFFC to 0
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        ifc.redirect_valid = 1'b0;
        expect_instr(32'hFFFF_FFFC);
        expect_instr(32'h0000_0000);
        grant_n(2, 32'hFFFF_FFFC);
        wait_drain();

        // Misaligned redirect
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h102;
        tick();
        ifc.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_FAULT_EN
        ifc.imem_gnt = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t7_req_halted", ifc.imem_req, 32'd0);
            check("t7_fault", ifc.fetch_fault, 32'd1);
            tick();
        end
        ifc.imem_gnt = 1'b0;
        do_reset();
        @(negedge clk);
        check("t7_fault_cleared", ifc.fetch_fault, 32'd0);
        check("t7_req_after_reset", ifc.imem_req, 32'd1);
`else
        @(negedge clk);
        check("t7_fault", ifc.fetch_fault, 32'd0);
        check("t7_addr_aligned", ifc.imem_addr, 32'h100);
        tick();
        expect_instr(32'h100);
        grant_n(1, 32'h100);
        wait_drain();
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
